ifft_iter: RTL and testbench

Iterative radix-2 inverse FFT engine. Takes an N-point Q15 complex spectrum as parallel arrays, computes the scaled inverse transform in place with a single time-shared butterfly, and presents N time-domain Q15 samples on parallel output arrays. It is the return path for the FFT core: spectra it produces, after optional processing, are converted back to samples here.

---
 rtl/ifft_pkg.sv | 36 +++
 rtl/ifft_bfly.sv | 64 ++++++
 rtl/ifft_iter.sv | 115 +++++++++++
 tb/tb_ifft_iter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_pkg.sv
// Shared types and constants for the iterative inverse FFT: FSM states, index helpers
// and the Q15 twiddle ROM (generated for a 16-point transform).
package ifft_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMP, OUT} state_t;

    localparam int ROM_N = 16;
    localparam int TW_W  = 16;

    // cos/sin(2*pi*k/16), k = 0..7; the unit entries are clipped to 0x7FFF
    localparam logic signed [TW_W-1:0] COS_ROM [ROM_N/2] = '{
        16'sd32767, 16'sd30274, 16'sd23170, 16'sd12540,
        16'sd0, -16'sd12540, -16'sd23170, -16'sd30274
    };
    localparam logic signed [TW_W-1:0] SIN_ROM [ROM_N/2] = '{
        16'sd0, 16'sd12540, 16'sd23170, 16'sd30274,
        16'sd32767, 16'sd30274, 16'sd23170, 16'sd12540
    };

    function automatic int log2n(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic int bit_rev(input int idx, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++)
            r = (r << 1) | ((idx >> i) & 1);
        return r;
    endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 inverse butterfly with per-stage halving.
// IFFT_ROUND_EN selects round-half-up plus saturation; default is floor truncation.
module ifft_bfly
    import ifft_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] ar,
    input  logic signed [DATA_WIDTH-1:0] ai,
    input  logic signed [DATA_WIDTH-1:0] br,
    input  logic signed [DATA_WIDTH-1:0] bi,
    input  logic signed [TW_W-1:0]       wr,
    input  logic signed [TW_W-1:0]       wi,
    output logic signed [DATA_WIDTH-1:0] new_ar,
    output logic signed [DATA_WIDTH-1:0] new_ai,
    output logic signed [DATA_WIDTH-1:0] new_br,
    output logic signed [DATA_WIDTH-1:0] new_bi
);

    localparam int PW    = DATA_WIDTH + TW_W + 1;
    localparam int SUM_W = DATA_WIDTH + 1;

`ifdef IFFT_ROUND_EN
    localparam logic signed [PW-1:0] MAX_V = PW'((1 <<< (DATA_WIDTH-1)) - 1);
    localparam logic signed [PW-1:0] MIN_V = -MAX_V - PW'(1);

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > MAX_V) return DATA_WIDTH'(MAX_V);
        if (v < MIN_V) return DATA_WIDTH'(MIN_V);
        return DATA_WIDTH'(v);
    endfunction
`endif

    function automatic logic signed [DATA_WIDTH-1:0] reduce(input logic signed [PW-1:0] p);
`ifdef IFFT_ROUND_EN
        return sat((p + (PW'(1) <<< (DATA_WIDTH-2))) >>> (DATA_WIDTH-1));
`else
        return DATA_WIDTH'(p >>> (DATA_WIDTH-1));
`endif
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] halve(input logic signed [SUM_W-1:0] s);
`ifdef IFFT_ROUND_EN
        return sat(PW'((s + SUM_W'(1)) >>> 1));
`else
        return DATA_WIDTH'(s >>> 1);
`endif
    endfunction

    logic signed [PW-1:0]         prod_r, prod_i;
    logic signed [DATA_WIDTH-1:0] tr, ti;

    always_comb begin
        prod_r = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
        prod_i = PW'(bi) * PW'(wr) + PW'(br) * PW'(wi);
        tr     = reduce(prod_r);
        ti     = reduce(prod_i);
        new_ar = halve(SUM_W'(ar) + SUM_W'(tr));
        new_ai = halve(SUM_W'(ai) + SUM_W'(ti));
        new_br = halve(SUM_W'(ar) - SUM_W'(tr));
        new_bi = halve(SUM_W'(ai) - SUM_W'(ti));
    end

endmodule

// File: rtl/ifft_iter.sv
// Iterative radix-2 inverse FFT: bit-reversed load, one in-place butterfly per cycle, 1/N scaled.
// Optional IFFT_ROUND_EN (in ifft_bfly) switches truncation to rounding with saturation.
module ifft_iter
    import ifft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] Zr [N],
    input  logic signed [DATA_WIDTH-1:0] Zi [N],
    output logic signed [DATA_WIDTH-1:0] zr [N],
    output logic signed [DATA_WIDTH-1:0] zi [N],
    output logic                         busy,
    output logic                         done
);

    localparam int LOG2N  = log2n(N);
    localparam int SW     = $clog2(LOG2N);
    localparam int JW     = LOG2N - 1;
    localparam int ROM_AW = $clog2(ROM_N / 2);

    state_t                       state;
    logic [SW-1:0]                stage;
    logic [JW-1:0]                bfly;
    logic signed [DATA_WIDTH-1:0] mem_r [N];
    logic signed [DATA_WIDTH-1:0] mem_i [N];
    logic [LOG2N-1:0]             pos, idx_a, idx_b, tw_k;
    logic [ROM_AW-1:0]            rom_idx;
    logic signed [DATA_WIDTH-1:0] new_ar, new_ai, new_br, new_bi;

    // Counter j splits into group (upper bits) and position within the span (lower s bits)
    always_comb begin
        pos     = LOG2N'(bfly) & ((LOG2N'(1) << stage) - LOG2N'(1));
        idx_a   = ((LOG2N'(bfly) - pos) << 1) | pos;
        idx_b   = idx_a | (LOG2N'(1) << stage);
        tw_k    = pos << (LOG2N - 1 - int'(stage));
        rom_idx = ROM_AW'(int'(tw_k) * (ROM_N / N));
    end

    ifft_bfly #(.DATA_WIDTH(DATA_WIDTH)) u_bfly (
        .ar     (mem_r[idx_a]),
        .ai     (mem_i[idx_a]),
        .br     (mem_r[idx_b]),
        .bi     (mem_i[idx_b]),
        .wr     (COS_ROM[rom_idx]),
        .wi     (SIN_ROM[rom_idx]),
        .new_ar (new_ar),
        .new_ai (new_ai),
        .new_br (new_br),
        .new_bi (new_bi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            stage <= '0;
            bfly  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= '0;
                mem_i[i] <= '0;
                zr[i]    <= '0;
                zi[i]    <= '0;
            end
        end else if (enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < N; i++) begin
                        mem_r[i] <= Zr[LOG2N'(bit_rev(i, LOG2N))];
                        mem_i[i] <= Zi[LOG2N'(bit_rev(i, LOG2N))];
                    end
                    stage <= '0;
                    bfly  <= '0;
                    state <= COMP;
                end
                COMP: begin
                    mem_r[idx_a] <= new_ar;
                    mem_i[idx_a] <= new_ai;
                    mem_r[idx_b] <= new_br;
                    mem_i[idx_b] <= new_bi;
                    if (bfly == JW'(N/2 - 1)) begin
                        bfly <= '0;
                        if (stage == SW'(LOG2N - 1)) state <= OUT;
                        else                         stage <= stage + SW'(1);
                    end else begin
                        bfly <= bfly + JW'(1);
                    end
                end
                OUT: begin
                    for (int i = 0; i < N; i++) begin
                        zr[i] <= mem_r[i];
                        zi[i] <= mem_i[i];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_iter.sv
// Self-checking bench for ifft_iter: table vectors, random spectra against a behavioural
// Cooley-Tukey model, and hand-written timing sequences (held start, enable gaps, reset).
module tb_ifft_iter;

    localparam int  DW = 16;
    localparam int  NP = 16;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst_n, enable, start;
    logic signed [DW-1:0] spec_r [NP];
    logic signed [DW-1:0] spec_i [NP];
    logic signed [DW-1:0] time_r [NP];
    logic signed [DW-1:0] time_i [NP];
    logic busy, done;

    int checks = 0;
    int errors = 0;
    int in_r [NP], in_i [NP], exp_r [NP], exp_i [NP];
    int tw_c [NP/2], tw_s [NP/2];

    typedef struct {
        int bin; int re; int im;
        int zr0; int zi0; int zr1; int zi1;
    } vec_t;
    vec_t vecs [4];

    ifft_iter #(.DATA_WIDTH(DW), .N(NP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .Zr(spec_r), .Zi(spec_i), .zr(time_r), .zi(time_i),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    function automatic int brev4(input int n);
        return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
    endfunction

    // Textbook decimation-in-time inverse FFT with halving per stage and floor rounding
    task automatic model();
        int wr [NP];
        int wi [NP];
        int span, a, b, k, tr, ti, nar, nai, nbr, nbi;
        longint pr, pi;
        for (int n = 0; n < NP; n++) begin
            wr[n] = in_r[brev4(n)];
            wi[n] = in_i[brev4(n)];
        end
        for (int s = 0; s < 4; s++) begin
            span = 1 << s;
            for (int g = 0; g < NP; g += 2 * span) begin
                for (int p = 0; p < span; p++) begin
                    a  = g + p;
                    b  = a + span;
                    k  = p * (NP / (2 * span));
                    pr = longint'(tw_c[k]) * wr[b] - longint'(tw_s[k]) * wi[b];
                    pi = longint'(tw_c[k]) * wi[b] + longint'(tw_s[k]) * wr[b];
                    tr = int'(shortint'(pr >>> 15));
                    ti = int'(shortint'(pi >>> 15));
                    nar = (wr[a] + tr) >>> 1;
                    nai = (wi[a] + ti) >>> 1;
                    nbr = (wr[a] - tr) >>> 1;
                    nbi = (wi[a] - ti) >>> 1;
                    wr[a] = nar; wi[a] = nai;
                    wr[b] = nbr; wi[b] = nbi;
                end
            end
        end
        for (int n = 0; n < NP; n++) begin
            exp_r[n] = wr[n];
            exp_i[n] = wi[n];
        end
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < NP; n++) begin
            in_r[n] = 0;
            in_i[n] = 0;
        end
    endtask

    task automatic load_inputs();
        for (int n = 0; n < NP; n++) begin
            spec_r[n] = DW'(in_r[n]);
            spec_i[n] = DW'(in_i[n]);
        end
    endtask

    task automatic compare_all(input string tag);
        model();
        for (int n = 0; n < NP; n++) begin
            chk($sformatf("%s zr[%0d]", tag, n), int'(time_r[n]), exp_r[n]);
            chk($sformatf("%s zi[%0d]", tag, n), int'(time_i[n]), exp_i[n]);
        end
    endtask

    // Edge 0 samples start; returns the edge index after which done is seen (-1 on timeout)
    task automatic run_xform(input int lo_at, input int lo_len, input bit scramble,
                             output int dedge, output bit busy_ok);
        dedge   = -1;
        busy_ok = 1'b1;
        start   = 1'b1;
        enable  = 1'b1;
        for (int e = 0; e < 200; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dedge = e;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (scramble && e == 1) begin
                for (int n = 0; n < NP; n++) begin
                    spec_r[n] = DW'($urandom);
                    spec_i[n] = DW'($urandom);
                end
            end
            enable = !((e + 1) >= lo_at && (e + 1) < lo_at + lo_len);
        end
        enable = 1'b1;
    endtask

    int  dedge, first_done, second_done, ndone;
    bit  bok;

    initial begin
        for (int k = 0; k < NP / 2; k++) begin
            tw_c[k] = int'(32768.0 * $cos(2.0 * PI * k / NP));
            tw_s[k] = int'(32768.0 * $sin(2.0 * PI * k / NP));
            if (tw_c[k] > 32767) tw_c[k] = 32767;
            if (tw_s[k] > 32767) tw_s[k] = 32767;
        end
        vecs[0] = '{0,  32767,     0,  2047,    0,  2047,    0};
        vecs[1] = '{1,  32767,     0,  2047,    0,  1891,  783};
        vecs[2] = '{0, -32768,     0, -2048,    0, -2048,    0};
        vecs[3] = '{0,      0, 32767,     0, 2047,     0, 2047};

        rst_n  = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        clear_inputs();
        load_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        for (int n = 0; n < NP; n++) begin
            chk($sformatf("reset zr[%0d]", n), int'(time_r[n]), 0);
            chk($sformatf("reset zi[%0d]", n), int'(time_i[n]), 0);
        end

        for (int v = 0; v < 4; v++) begin
            clear_inputs();
            in_r[vecs[v].bin] = vecs[v].re;
            in_i[vecs[v].bin] = vecs[v].im;
            load_inputs();
            run_xform(0, 0, 1'b0, dedge, bok);
            chk($sformatf("vec%0d done_cycle", v), dedge, 34);
            chk($sformatf("vec%0d busy_held", v), int'(bok), 1);
            chk($sformatf("vec%0d busy_after", v), int'(busy), 0);
            chk($sformatf("vec%0d zr0", v), int'(time_r[0]), vecs[v].zr0);
            chk($sformatf("vec%0d zi0", v), int'(time_i[0]), vecs[v].zi0);
            chk($sformatf("vec%0d zr1", v), int'(time_r[1]), vecs[v].zr1);
            chk($sformatf("vec%0d zi1", v), int'(time_i[1]), vecs[v].zi1);
            compare_all($sformatf("vec%0d", v));
            @(posedge clk);
            #1 chk($sformatf("vec%0d done_pulse", v), int'(done), 0);
        end

        clear_inputs();
        in_r[0] = 32767;
        load_inputs();
        run_xform(0, 0, 1'b0, dedge, bok);
        for (int n = 0; n < NP; n++)
            chk($sformatf("impulse zr[%0d]", n), int'(time_r[n]), 2047);

        clear_inputs();
        in_r[1] = 32767;
        load_inputs();
        run_xform(0, 0, 1'b0, dedge, bok);
        for (int n = 0; n < NP; n++) begin
            chk_near($sformatf("tone zr[%0d]", n), int'(time_r[n]),
                     int'(2047.0 * $cos(2.0 * PI * n / NP)), 2);
            chk_near($sformatf("tone zi[%0d]", n), int'(time_i[n]),
                     int'(2047.0 * $sin(2.0 * PI * n / NP)), 2);
        end

        clear_inputs();
        for (int n = 0; n < NP; n++) in_r[n] = 32767;
        load_inputs();
        run_xform(0, 0, 1'b0, dedge, bok);
        chk_near("flat zr[0]", int'(time_r[0]), 32767, 8);
        for (int n = 1; n < NP; n++)
            chk_near($sformatf("flat zr[%0d]", n), int'(time_r[n]), 0, 2);
        for (int n = 0; n < NP; n++)
            chk_near($sformatf("flat zi[%0d]", n), int'(time_i[n]), 0, 2);
        compare_all("flat");

        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < NP; n++) begin
                in_r[n] = int'(shortint'($urandom));
                in_i[n] = int'(shortint'($urandom));
            end
            load_inputs();
            run_xform(0, 0, r == 0, dedge, bok);
            chk($sformatf("rand%0d done_cycle", r), dedge, 34);
            compare_all($sformatf("rand%0d", r));
        end

        // start held for 60 cycles: only IDLE samples it, so two transforms 35 edges apart
        clear_inputs();
        in_r[0] = 32767;
        load_inputs();
        first_done  = -1;
        second_done = -1;
        ndone       = 0;
        bok         = 1'b1;
        start       = 1'b1;
        for (int e = 0; e < 90; e++) begin
            @(posedge clk);
            #1;
            if (e == 59) start = 1'b0;
            if (done) begin
                ndone++;
                if (first_done < 0)       first_done  = e;
                else if (second_done < 0) second_done = e;
            end
            if ((e <= 33 || (e >= 35 && e <= 68)) && !busy) bok = 1'b0;
        end
        chk("held_start done_count", ndone, 2);
        chk("held_start first_done", first_done, 34);
        chk("held_start second_done", second_done, 69);
        chk("held_start busy_held", int'(bok), 1);

        clear_inputs();
        in_r[0] = 32767;
        load_inputs();
        run_xform(10, 5, 1'b0, dedge, bok);
        chk("enable_gap done_cycle", dedge, 39);
        compare_all("enable_gap");

        clear_inputs();
        in_r[1] = 12345;
        in_i[3] = -7000;
        load_inputs();
        start = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", int'(busy), 0);
        chk("midreset done", int'(done), 0);
        for (int n = 0; n < NP; n++) begin
            chk($sformatf("midreset zr[%0d]", n), int'(time_r[n]), 0);
            chk($sformatf("midreset zi[%0d]", n), int'(time_i[n]), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("midreset stays idle", int'(busy), 0);
        run_xform(0, 0, 1'b0, dedge, bok);
        chk("after_reset done_cycle", dedge, 34);
        compare_all("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
